ysyx_22051468_reg_scoreboard: RTL and testbench

- Register-dependency scoreboard between decode and execute issue. Consumes the per-instruction rd/rs1/rs2 need flags and register indices produced by decode.
- Tracks outstanding writes per architectural register and gates issue with a ready signal until every required source is free. Writeback retires entries.
- Flush discards all in-flight state, e.g. on a branch mispredict or trap redirect.

---
 rtl/ysyx_22051468_reg_scoreboard.sv | 67 ++++++
 tb/tb_ysyx_22051468_reg_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051468_reg_scoreboard.sv
// ysyx_22051468_reg_scoreboard: per-register outstanding-write tracker gating decode-to-execute issue
module ysyx_22051468_reg_scoreboard #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32,
    localparam int IW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [IW-1:0]     rd,
    input  logic [IW-1:0]     rs1,
    input  logic [IW-1:0]     rs2,
    input  logic              rd_need,
    input  logic              rs1_need,
    input  logic              rs2_need,
    input  logic              wb_valid,
    input  logic [IW-1:0]     wb_rd,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              wb_err
);
    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             hazard;
    logic             fire;
    logic             wb_bad;

    // Busy flags and per-register inc/dec strobes; x0 never tracked
    always_comb begin
        busy_vec = '0;
        inc_vec  = '0;
        dec_vec  = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_vec[i] = |cnt[i];
            inc_vec[i]  = (i != 0) && fire && rd_need && (rd == IW'(i));
            dec_vec[i]  = (i != 0) && wb_valid && (wb_rd == IW'(i)) && (|cnt[i]);
        end
    end

    assign hazard      = (rs1_need & busy_vec[rs1]) | (rs2_need & busy_vec[rs2])
                       | (rd_need & (|rd) & (&cnt[rd]));
    assign issue_ready = !hazard && !flush;
    assign fire        = issue_valid && issue_ready;
    assign wb_bad      = wb_valid && (|wb_rd) && !(|cnt[wb_rd]);

    // Counters, stall counter and sticky writeback error; flush wins over inc/dec
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt + PERF_W'(issue_valid && !issue_ready);
            if (flush) begin
                for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            end else begin
                for (int r = 0; r < NREG; r++)
                    cnt[r] <= cnt[r] + CNT_W'(inc_vec[r]) - CNT_W'(dec_vec[r]);
                if (wb_bad) wb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22051468_reg_scoreboard.sv
// tb_ysyx_22051468_reg_scoreboard: directed self-checking bench for the register scoreboard
module tb_ysyx_22051468_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_need;
    logic        rs1_need;
    logic        rs2_need;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;
    logic        wb_err;
    int          checks = 0;
    int          fails  = 0;

    ysyx_22051468_reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rd(rd), .rs1(rs1), .rs2(rs2), .rd_need(rd_need), .rs1_need(rs1_need),
        .rs2_need(rs2_need), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic [4:0] d, input logic dn,
                       input logic [4:0] s1, input logic n1, input logic [4:0] s2, input logic n2);
        issue_valid = v; rd = d; rd_need = dn; rs1 = s1; rs1_need = n1; rs2 = s2; rs2_need = n2;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] d);
        wb_valid = v; wb_rd = d;
        #1;
    endtask

    // Directed sequence following the test plan
    initial begin
        rst_n = 1'b0; flush = 1'b0;
        iss(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_ready", issue_ready, 1);
        // RAW hazard on x5
        iss(1, 5, 1, 0, 0, 0, 0);
        chk("raw_c0_ready", issue_ready, 1);
        tick();
        iss(1, 0, 0, 5, 1, 0, 0);
        chk("raw_c1_busy5", busy_vec[5], 1);
        chk("raw_c1_ready", issue_ready, 0);
        tick();
        chk("raw_c2_ready", issue_ready, 0);
        tick();
        wb(1, 5);
        chk("raw_c3_ready_nobypass", issue_ready, 0);
        tick();
        wb(0, 0);
        chk("raw_c4_ready", issue_ready, 1);
        chk("raw_c4_busy", busy_vec, 0);
        chk("raw_stall", stall_cnt, 3);
        tick();
        // Need flags and x0
        iss(1, 5, 1, 0, 0, 0, 0);
        tick();
        iss(1, 0, 0, 0, 0, 5, 0);
        chk("rs2_noneed_ready", issue_ready, 1);
        tick();
        iss(1, 0, 1, 0, 0, 0, 0);
        chk("rd0_ready", issue_ready, 1);
        tick();
        iss(0, 0, 0, 0, 0, 0, 0);
        chk("rd0_busy", busy_vec, 32'h20);
        wb(1, 0);
        tick();
        chk("wb0_no_err", wb_err, 0);
        wb(1, 5);
        tick();
        wb(0, 0);
        chk("x5_drained", busy_vec, 0);
        // Saturation of x7
        iss(1, 7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sat_fill_ready", issue_ready, 1);
            tick();
        end
        chk("sat_busy7", busy_vec, 32'h80);
        chk("sat_4th_ready", issue_ready, 0);
        wb(1, 7);
        chk("sat_wb_same_cycle_ready", issue_ready, 0);
        tick();
        wb(0, 0);
        chk("sat_after_wb_ready", issue_ready, 1);
        tick();
        iss(0, 7, 1, 0, 0, 0, 0);
        chk("sat_again_ready", issue_ready, 0);
        iss(0, 0, 0, 0, 0, 0, 0);
        wb(1, 7);
        tick(); tick();
        chk("sat_two_left", busy_vec, 32'h80);
        tick();
        wb(0, 0);
        chk("sat_drained", busy_vec, 0);
        chk("sat_no_err", wb_err, 0);
        // Simultaneous issue and writeback on x9
        iss(1, 9, 1, 0, 0, 0, 0);
        tick();
        wb(1, 9);
        chk("sim_ready", issue_ready, 1);
        tick();
        iss(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        chk("sim_busy9", busy_vec, 32'h200);
        wb(1, 9);
        tick();
        wb(0, 0);
        chk("sim_drained", busy_vec, 0);
        chk("sim_no_err", wb_err, 0);
        // Flush with concurrent writeback and blocked issue
        iss(1, 3, 1, 0, 0, 0, 0);
        tick();
        iss(1, 4, 1, 0, 0, 0, 0);
        tick();
        chk("fl_busy34", busy_vec, 32'h18);
        flush = 1'b1;
        iss(1, 6, 1, 0, 0, 0, 0);
        wb(1, 3);
        chk("fl_ready", issue_ready, 0);
        tick();
        flush = 1'b0;
        iss(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        chk("fl_busy", busy_vec, 0);
        chk("fl_wb_err", wb_err, 0);
        chk("fl_stall", stall_cnt, 5);
        wb(1, 3);
        tick();
        wb(0, 0);
        chk("late_wb_err", wb_err, 1);
        tick(); tick();
        chk("wb_err_sticky", wb_err, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_wb_err", wb_err, 0);
        chk("rst2_stall", stall_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
